ps2_command_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte (LED set, reset, typematic rate, etc.) to the keyboard on the shared `ps2_clk`/`ps2_data` open-drain lines. It is the transmit counterpart of the `ps2` frame receiver and sits beside it in `top`. Commands arrive on a ready/valid byte handshake. The block drives the lines only through active-low enables, reports the device ACK as a one-cycle result, and raises `busy` so the receiver ignores line activity it causes.

---
 rtl/ps2_command_tx.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_command_tx.sv
// ---------------------------------------------------------------------------
// ps2_command_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over
// the shared open-drain ps2_clk / ps2_data lines. The lines are only ever
// pulled low through active-low drive enables; releasing a line means leaving
// it to the external pull-up.
//
// Transaction sequence:
//   1. Accept a byte on the ready/valid handshake.
//   2. Hold the clock line low for INHIBIT_CYCLES. The start bit (data low)
//      is applied on the last inhibit cycle.
//   3. Release the clock. The device now generates clock pulses, and on each
//      falling edge the next frame bit is presented: byte LSB first, odd
//      parity, then stop (line released).
//   4. On the following falling edge, sample the device ACK (data low = ACK).
//   5. Wait for both lines to return high, then report the result for one
//      cycle.
//
// A timeout started at clock release aborts the transaction, releases both
// lines and reports an error.
//
// Configuration macro:
//   PS2_TX_RETRY_EN - when defined, a NACK or timeout causes one automatic
//                     resend of the same frame before an error is reported.
//
// Parameters:
//   CLK        - system clock frequency in Hz
//   INHIBIT_US - clock-inhibit time before the start bit, in microseconds
//   TIMEOUT_US - limit from clock release to ACK sample, in microseconds
//
// Ports:
//   clk                - system clock
//   reset              - synchronous, active-high reset
//   command_ready      - block can accept a command byte
//   command_valid      - command byte offered by the source
//   command_byte       - command to send
//   ps2_clk_in         - raw pin level of ps2_clk
//   ps2_data_in        - raw pin level of ps2_data
//   ps2_clk_drive_low  - 1 pulls ps2_clk low, 0 releases it
//   ps2_data_drive_low - 1 pulls ps2_data low, 0 releases it
//   busy               - transaction in progress (receiver should ignore line)
//   result_valid       - one-cycle pulse at transaction end
//   result_error       - qualified by result_valid; 1 = NACK or timeout
// ---------------------------------------------------------------------------
module ps2_command_tx #(
    parameter int CLK        = 51_800_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15_000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       command_ready,
    input  logic       command_valid,
    input  logic [7:0] command_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       result_valid,
    output logic       result_error
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int INHIBIT_CYCLES = CLK / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYCLES = CLK / 1_000_000 * TIMEOUT_US;
    localparam int MAX_CYCLES     = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W          = $clog2(MAX_CYCLES) + 1;

    // Counters are loaded with (length - 1) so that the state is occupied for
    // exactly "length" cycles before the zero value is acted upon.
    localparam logic [CNT_W-1:0] INHIBIT_LOAD =
        CNT_W'((INHIBIT_CYCLES > 0) ? INHIBIT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // With a one-cycle inhibit the acceptance cycle is also the last inhibit
    // cycle, so the start bit must already be applied on acceptance.
    localparam logic START_AT_ACCEPT = (INHIBIT_CYCLES <= 1);

`ifdef PS2_TX_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_RELEASE,
        S_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Pin synchronisers and falling-edge detection
    // -----------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle-high reset values avoid a false falling edge after reset.
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    // -----------------------------------------------------------------------
    // Transmit state
    // -----------------------------------------------------------------------
    state_t           state_q;
    logic             ready_q;
    logic             clk_low_q;
    logic             data_low_q;
    logic             busy_q;
    logic             result_valid_q;
    logic             result_error_q;
    logic [9:0]       frame_q;      // shifting copy, LSB is next bit out
    logic [9:0]       frame_save_q; // untouched copy for a resend
    logic [3:0]       bit_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             nack_q;
    logic             retried_q;

    // Combinational helpers
    logic             fall_d;
    logic [9:0]       frame_d;
    logic [CNT_W-1:0] cnt_dec_d;
    logic             timeout_d;
    logic             released_d;
    logic             finish_d;
    logic             fail_d;
    logic             retry_d;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        fall_d     = 1'b0;
        frame_d    = '0;
        cnt_dec_d  = '0;
        timeout_d  = 1'b0;
        released_d = 1'b0;

        fall_d  = clk_prev_q & ~clk_sync_q[1];
        frame_d = {1'b1, ~^command_byte, command_byte};

        // Saturating decrement: the counter never wraps below zero.
        cnt_dec_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

        timeout_d  = ((state_q == S_SEND) || (state_q == S_ACK) ||
                      (state_q == S_RELEASE)) && (cnt_q == '0);
        released_d = (state_q == S_RELEASE) && clk_sync_q[1] && data_sync_q[1];
    end

    assign finish_d = timeout_d | released_d;
    assign fail_d   = timeout_d | (released_d & nack_q);
    assign retry_d  = RETRY_EN & fail_d & ~retried_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ready_q        <= 1'b0;
            clk_low_q      <= 1'b0;
            data_low_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_error_q <= 1'b0;
            frame_q        <= '0;
            frame_save_q   <= '0;
            bit_cnt_q      <= '0;
            cnt_q          <= '0;
            nack_q         <= 1'b0;
            retried_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;

            if (finish_d) begin
                // End of an attempt: either success, a reportable failure,
                // or (retry build only) a second attempt from INHIBIT.
                if (retry_d) begin
                    frame_q    <= frame_save_q;
                    cnt_q      <= INHIBIT_LOAD;
                    clk_low_q  <= 1'b1;
                    data_low_q <= START_AT_ACCEPT;
                    retried_q  <= 1'b1;
                    state_q    <= S_INHIBIT;
                end else begin
                    clk_low_q      <= 1'b0;
                    data_low_q     <= 1'b0;
                    result_valid_q <= 1'b1;
                    result_error_q <= fail_d;
                    state_q        <= S_DONE;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        result_error_q <= 1'b0;
                        if (command_valid && ready_q) begin
                            frame_q      <= frame_d;
                            frame_save_q <= frame_d;
                            cnt_q        <= INHIBIT_LOAD;
                            clk_low_q    <= 1'b1;
                            data_low_q   <= START_AT_ACCEPT;
                            busy_q       <= 1'b1;
                            ready_q      <= 1'b0;
                            retried_q    <= 1'b0;
                            state_q      <= S_INHIBIT;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end

                    S_INHIBIT: begin
                        cnt_q <= cnt_dec_d;
                        // Start bit goes out during the last inhibit cycle,
                        // while the clock is still held low.
                        if (cnt_q == CNT_W'(1)) begin
                            data_low_q <= 1'b1;
                        end
                        if (cnt_q == '0) begin
                            clk_low_q  <= 1'b0;
                            data_low_q <= 1'b1;
                            cnt_q      <= TIMEOUT_LOAD;
                            bit_cnt_q  <= '0;
                            state_q    <= S_SEND;
                        end
                    end

                    S_SEND: begin
                        cnt_q <= cnt_dec_d;
                        if (fall_d) begin
                            data_low_q <= ~frame_q[0];
                            frame_q    <= {1'b1, frame_q[9:1]};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            // Tenth edge puts the stop bit (released line).
                            if (bit_cnt_q == 4'd9) begin
                                state_q <= S_ACK;
                            end
                        end
                    end

                    S_ACK: begin
                        cnt_q <= cnt_dec_d;
                        if (fall_d) begin
                            nack_q  <= data_sync_q[1];
                            state_q <= S_RELEASE;
                        end
                    end

                    S_RELEASE: begin
                        // Exit handled by finish_d once both lines are high.
                        cnt_q <= cnt_dec_d;
                    end

                    S_DONE: begin
                        result_error_q <= 1'b0;
                        busy_q         <= 1'b0;
                        ready_q        <= 1'b1;
                        state_q        <= S_IDLE;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign command_ready      = ready_q;
    assign ps2_clk_drive_low  = clk_low_q;
    assign ps2_data_drive_low = data_low_q;
    assign busy               = busy_q;
    assign result_valid       = result_valid_q;
    assign result_error       = result_error_q;

endmodule
